calc_seq_core: RTL and testbench

//  Parametrised multi-cycle integer calculator core; successor to the fixed 32-bit combinational calculator.

---
 rtl/calc_seq_core_if.sv | 56 +++++
 rtl/calc_seq_core.sv | 253 +++++++++++++++++++++++++
 tb/tb_calc_seq_core.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_seq_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : calc_seq_core_if                                             |
// | Description : Operand/result handshake bundle for calc_seq_core. The       |
// |               master side presents operands and consumes results; the      |
// |               slave side is the calculator core.                           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface calc_seq_core_if #(
  parameter int WIDTH = 32
) ();

  // Request side
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [1:0]         op;

  // Response side
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               div_zero;

  // Status
  logic               busy;

  modport master (
    output in_valid,
    output a,
    output b,
    output op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  div_zero,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output div_zero,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/calc_seq_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : calc_seq_core                                                |
// | Description : Multi-cycle integer calculator. add/sub finish in one EXEC   |
// |               cycle; mul (shift-add) and div (restoring) retire one bit    |
// |               per cycle for WIDTH cycles. Result is 2*WIDTH bits wide.     |
// |               Optional macro CALC_SIGNED_EN: mul/div operate on two's      |
// |               complement operands via magnitudes plus one sign-fix cycle.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module calc_seq_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1   // derived; leave at default
) (
  input  wire logic      clk,
  input  wire logic      rst,
  calc_seq_core_if.slave bus
);

  localparam int W2 = 2 * WIDTH;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef CALC_SIGNED_EN
  localparam logic [1:0] S_SIGN = 2'd3;
`endif

  // Control state
  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Datapath: opnd holds the multiplicand / divisor / add-sub "a";
  // acc holds {hi, lo} = {partial product, multiplier} or {remainder, quotient}.
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             dz_q, dz_d;          // divide-by-zero seen at accept

  // Visible result registers, hold their value after the handoff
  logic [W2-1:0]    result_q, result_d;
  logic             div_zero_q, div_zero_d;

`ifdef CALC_SIGNED_EN
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] fix_quot;
  logic [WIDTH-1:0] fix_rem;
  logic [W2-1:0]    fix_res;
`endif

  logic             accept;
  logic             cnt_zero;
  logic             op_iter;
  logic [WIDTH-1:0] ld_a;
  logic [WIDTH-1:0] ld_b;
  logic [W2-1:0]    addsub_res;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_next;
  logic [W2-1:0]    step_next;

  assign accept   = (state_q == S_IDLE) && bus.in_valid;
  assign cnt_zero = (cnt_q == '0);
  assign op_iter  = (bus.op == OP_MUL) || (bus.op == OP_DIV);

  // Operand conditioning at accept: magnitudes for signed mul/div, raw otherwise
  always_comb begin
    ld_a = bus.a;
    ld_b = bus.b;
`ifdef CALC_SIGNED_EN
    if (op_iter) begin
      if (bus.a[WIDTH-1]) ld_a = -bus.a;
      if (bus.b[WIDTH-1]) ld_b = -bus.b;
    end
`else
`endif
  end

  // One iteration of each arithmetic unit, evaluated from the current registers
  always_comb begin
    // add/sub on zero-extended operands; sub wraps modulo 2^(2*WIDTH)
    if (op_q == OP_ADD) begin
      addsub_res = {{WIDTH{1'b0}}, opnd_q} + {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
    end else begin
      addsub_res = {{WIDTH{1'b0}}, opnd_q} - {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
    end

    // shift-add: conditionally add multiplicand to upper half, shift right one
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // restoring divide: shift next dividend bit into remainder, trial-subtract;
    // the trial's top bit is the borrow (remainder < divisor)
    div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    div_rem   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], ~div_trial[WIDTH]};

    step_next = (op_q == OP_DIV) ? div_next : mul_next;
  end

`ifdef CALC_SIGNED_EN
  // Sign restoration of the magnitude result (quotient left at all ones on /0)
  always_comb begin
    fix_quot = acc_q[WIDTH-1:0];
    fix_rem  = acc_q[W2-1:WIDTH];
    if ((neg_a_q ^ neg_b_q) && !dz_q) fix_quot = -acc_q[WIDTH-1:0];
    if (neg_a_q)                      fix_rem  = -acc_q[W2-1:WIDTH];
    if (op_q == OP_DIV) begin
      fix_res = {fix_rem, fix_quot};
    end else begin
      fix_res = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    end
  end
`else
`endif

  // Datapath next-state: load at accept, iterate in EXEC, publish result on completion
  always_comb begin
    op_d       = op_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dz_d       = dz_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;
`ifdef CALC_SIGNED_EN
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
`endif

    if (accept) begin
      op_d = bus.op;
      dz_d = (bus.op == OP_DIV) && (bus.b == '0);
      // divide keeps the divisor in opnd and the dividend in acc; others the reverse
      if (bus.op == OP_DIV) begin
        opnd_d = ld_b;
        acc_d  = {{WIDTH{1'b0}}, ld_a};
      end else begin
        opnd_d = ld_a;
        acc_d  = {{WIDTH{1'b0}}, ld_b};
      end
      cnt_d = op_iter ? CNT_W'(WIDTH - 1) : '0;
`ifdef CALC_SIGNED_EN
      neg_a_d = bus.a[WIDTH-1];
      neg_b_d = bus.b[WIDTH-1];
`endif
    end else if (state_q == S_EXEC) begin
      if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
      if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
        result_d   = addsub_res;
        div_zero_d = 1'b0;
      end else begin
        acc_d = step_next;
`ifdef CALC_SIGNED_EN
        // result is published after the sign-fix cycle
`else
        if (cnt_zero) begin
          result_d   = step_next;
          div_zero_d = dz_q;
        end
`endif
      end
    end
`ifdef CALC_SIGNED_EN
    else if (state_q == S_SIGN) begin
      result_d   = fix_res;
      div_zero_d = dz_q;
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: IDLE -> EXEC -> [SIGN ->] DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid) state_d = S_EXEC;
      S_EXEC: begin
        if (cnt_zero) begin
`ifdef CALC_SIGNED_EN
          state_d = ((op_q == OP_MUL) || (op_q == OP_DIV)) ? S_SIGN : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
`ifdef CALC_SIGNED_EN
      default: state_d = S_DONE;   // S_SIGN lasts exactly one cycle
`else
      default: state_d = S_IDLE;   // unreachable encoding, recover to idle
`endif
    endcase
  end

  // FSM outputs: handshake flags decoded from state, result from its register
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.busy      = (state_q != S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    bus.result    = result_q;
    bus.div_zero  = div_zero_q;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_ADD;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      dz_q       <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
`ifdef CALC_SIGNED_EN
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
`endif
    end else begin
      op_q       <= op_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dz_q       <= dz_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
`ifdef CALC_SIGNED_EN
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_calc_seq_core                                             |
// | Description : Self-checking bench for calc_seq_core (WIDTH=32): directed   |
// |               cases, randomized operations against an arithmetic model,    |
// |               result stalls, and an asynchronous reset during a multiply.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_calc_seq_core;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  calc_seq_core_if #(.WIDTH(W)) bus ();

  calc_seq_core #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: plain operators on the operand values
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op, output logic dz);
    logic [31:0] q;
    logic [31:0] r;
`ifdef CALC_SIGNED_EN
    longint      p;
    int          sa;
    int          sb;
`endif
    dz = 1'b0;
    case (op)
      2'b00: return {32'd0, a} + {32'd0, b};
      2'b01: return {32'd0, a} - {32'd0, b};
`ifdef CALC_SIGNED_EN
      2'b10: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      default: begin
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
          dz = 1'b1;
          return {a, 32'hFFFF_FFFF};
        end
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
`else
      2'b10: return {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1;
          return {a, 32'hFFFF_FFFF};
        end
        q = a / b;
        r = a % b;
        return {r, q};
      end
`endif
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
    if (op[1] == 1'b0) return 1;
`ifdef CALC_SIGNED_EN
    return W + 1;
`else
    return W;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_result"},    bus.result,         64'd0);
    check({tag, "_div_zero"},  64'(bus.div_zero),  64'd0);
  endtask

  // One full transaction; called just after a rising edge (+1) with the core idle.
  // hold=0 keeps out_ready high throughout EXEC (it must be ignored there).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input int hold, input string tag);
    logic [63:0] exp_res;
    logic        exp_dz;
    int          lat;
    exp_res = model(a, b, op, exp_dz);
    bus.a         = a;
    bus.b         = b;
    bus.op        = op;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    check({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    // operands change after acceptance and must not matter
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.op       = 2'($urandom);
    check({tag, "_busy_ready_exec"}, 64'({bus.busy, bus.in_ready}), 64'b10);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"},  64'(lat),          64'(exp_lat(op)));
    check({tag, "_result"},   bus.result,        exp_res);
    check({tag, "_div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_stall_flags"},  64'({bus.out_valid, bus.in_ready, bus.busy}), 64'b101);
      check({tag, "_stall_result"}, bus.result, exp_res);
    end
    // handshake edge with a simultaneous request that must not be taken
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check({tag, "_after_handoff"}, 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'b010);
    check({tag, "_result_held"},   bus.result, exp_res);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int          seen;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;

    #12;
    check_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(32'd16,         32'd4,         2'b10, 0,  "mul_16_4");
    run_op(32'd16,         32'd4,         2'b11, 2,  "div_16_4");
    run_op(32'd17,         32'd4,         2'b11, 0,  "div_17_4");
    run_op(32'd4,          32'd16,        2'b01, 10, "sub_4_16");
    run_op(32'hFFFF_FFFF,  32'hFFFF_FFFF, 2'b00, 1,  "add_max");
    run_op(32'hFFFF_FFFF,  32'hFFFF_FFFF, 2'b10, 0,  "mul_max");
    run_op(32'd5,          32'd9,         2'b11, 0,  "div_small_by_big");
`ifdef CALC_SIGNED_EN
    run_op(32'hFFFF_FFF0,  32'd4,         2'b11, 0,  "sdiv_m16_4");
    run_op(32'hFFFF_FFF9,  32'd2,         2'b11, 1,  "sdiv_m7_2");
    run_op(32'h8000_0000,  32'hFFFF_FFFF, 2'b11, 0,  "sdiv_minneg");
    run_op(32'hFFFF_FFFD,  32'd5,         2'b10, 0,  "smul_m3_5");
    run_op(32'hFFFF_FFF9,  32'd0,         2'b11, 0,  "sdiv_neg_by0");
`endif

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
      rop = 2'($urandom);
      run_op(ra, rb, rop, $urandom_range(0, 3), "rand");
    end

    // Divide by zero, leaves a nonzero result and div_zero=1 behind
    run_op(32'd7, 32'd0, 2'b11, 3, "div_7_0");

    // Asynchronous reset in the middle of a multiply
    bus.a         = 32'd16;
    bus.b         = 32'd4;
    bus.op        = 2'b10;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen++;
    end
    check("midrst_no_activity", 64'(seen), 64'd0);

    // Clean operation after the abort
    run_op(32'd16, 32'd4, 2'b10, 0, "post_rst_mul");
    run_op(32'd17, 32'd4, 2'b11, 0, "post_rst_div");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
